// File: rtl/dac_sample_arbiter.sv
// dac_sample_arbiter: shares one PWM DAC among NREQ requesters, arbitrating round-robin only at frame boundaries
//   clk       : system clock, rising edge
//   rst       : synchronous active-low reset
//   frame_end : one-cycle pulse at each PWM period boundary (DAC counter carry-out)
//   req       : per-requester request level, held until acked
//   data      : flattened samples, requester i at [i*WIDTH +: WIDTH]
//   ack       : one-hot, one-cycle pulse when a requester's sample is accepted
//   dac_data  : sample presented to the DAC (IDLE_LEVEL when no grant)
//   grant_id  : index of the current owner, 0 when idle
//   busy      : high while a grant is being held
module dac_sample_arbiter #(
    parameter int               NREQ        = 4,
    parameter int               WIDTH       = 8,
    parameter int               HOLD_FRAMES = 4,
    parameter logic [WIDTH-1:0] IDLE_LEVEL  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_end,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        dac_data,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_FRAMES + 1);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, gid_q, gid_d, win, idx;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic            busy_q, busy_d, found, arb;
    // the last frame of a hold is the one where the count reaches HOLD_FRAMES-1
    assign arb = frame_end && (state_q == IDLE || cnt_q == CW'(HOLD_FRAMES - 1));
    // first set request at or after the pointer, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            dac_q   <= IDLE_LEVEL;
            gid_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dac_q   <= dac_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
        end
    end
    always_comb begin
        state_d = arb ? (found ? HOLD : IDLE) : state_q;
        ptr_d   = (arb && found) ? IW'((int'(win) + 1) % NREQ) : ptr_q;
        cnt_d   = arb ? '0 : (frame_end ? cnt_q + 1'b1 : cnt_q);
    end
    always_comb begin
        ack_d  = (arb && found) ? NREQ'(1) << win : '0;
        dac_d  = arb ? (found ? data[int'(win)*WIDTH +: WIDTH] : IDLE_LEVEL) : dac_q;
        gid_d  = arb ? (found ? win : '0) : gid_q;
        busy_d = arb ? found : busy_q;
    end
    assign ack      = ack_q;
    assign dac_data = dac_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_dac_sample_arbiter.sv
// tb_dac_sample_arbiter: directed and random checks of dac_sample_arbiter against a frame-level reference model
//   drives a default (NREQ=4, HOLD_FRAMES=4) instance and a NREQ=2, HOLD_FRAMES=1 instance
module tb_dac_sample_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_end = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  ack;
    logic [7:0]  dac_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        fe2 = 1'b0;
    logic [1:0]  req2 = '0;
    logic [15:0] data2 = 16'hBBAA;
    logic [1:0]  ack2;
    logic [7:0]  dac2;
    logic [0:0]  gid2;
    logic        busy2;
    int          vecs = 0;
    int          errs = 0;
    int          m_owner, m_left, m_ptr;
    logic [7:0]  m_dac;
    logic [1:0]  m_gid;
    logic [3:0]  m_ack;
    logic        m_busy;
    int          seen[$];

    dac_sample_arbiter dut (
        .clk(clk), .rst(rst), .frame_end(frame_end), .req(req), .data(data),
        .ack(ack), .dac_data(dac_data), .grant_id(grant_id), .busy(busy)
    );

    dac_sample_arbiter #(.NREQ(2), .HOLD_FRAMES(1)) dut2 (
        .clk(clk), .rst(rst), .frame_end(fe2), .req(req2), .data(data2),
        .ack(ack2), .dac_data(dac2), .grant_id(gid2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // owner / frames-left view of the arbiter, advanced once per clock edge
    task automatic model_step();
        int w;
        if (!rst) begin
            m_owner = -1; m_left = 0; m_ptr = 0;
            m_dac = 8'h00; m_gid = '0; m_ack = '0; m_busy = 1'b0;
        end else begin
            m_ack = '0;
            if (frame_end) begin
                if (m_owner < 0 || m_left == 1) begin
                    w = -1;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                    if (w >= 0) begin
                        m_owner = w; m_left = 4; m_ptr = (w + 1) % 4;
                        m_dac = data[w*8 +: 8]; m_gid = 2'(w); m_ack = 4'(1 << w); m_busy = 1'b1;
                    end else begin
                        m_owner = -1; m_dac = 8'h00; m_gid = '0; m_busy = 1'b0;
                    end
                end else begin
                    m_left--;
                end
            end
        end
    endtask

    task automatic check();
        vecs++;
        assert (ack === m_ack) else begin errs++; $error("FAIL ack got %b exp %b", ack, m_ack); end
        vecs++;
        assert (dac_data === m_dac) else begin errs++; $error("FAIL dac_data got %h exp %h", dac_data, m_dac); end
        vecs++;
        assert (grant_id === m_gid) else begin errs++; $error("FAIL grant_id got %0d exp %0d", grant_id, m_gid); end
        vecs++;
        assert (busy === m_busy) else begin errs++; $error("FAIL busy got %b exp %b", busy, m_busy); end
        vecs++;
        assert ($countones(ack) <= 1) else begin errs++; $error("FAIL ack_onehot got %b exp <=1 bit", ack); end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check();
    endtask

    initial begin
        // reset with requests and frame pulses present
        req = 4'hF;
        data = 32'h44332211;
        for (int i = 0; i < 3; i++) begin
            frame_end = (i % 2 == 0);
            tick();
            vecs++;
            assert (busy === 1'b0 && ack === 4'b0 && dac_data === 8'h00 && grant_id === 2'd0)
                else begin errs++; $error("FAIL reset_outputs got %b/%h/%0d/%b exp 0", ack, dac_data, grant_id, busy); end
        end
        rst = 1'b1; req = '0; frame_end = 1'b0;
        tick();

        // single grant to requester 2, then hold through 4 frames with req dropped
        data = 32'h00A5_0000; req = 4'b0100; frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        vecs++;
        assert (ack === 4'b0100 && dac_data === 8'hA5 && grant_id === 2'd2 && busy === 1'b1)
            else begin errs++; $error("FAIL single_grant got %b/%h/%0d/%b exp 0100/a5/2/1", ack, dac_data, grant_id, busy); end
        req = '0;
        tick();
        vecs++;
        assert (ack === 4'b0) else begin errs++; $error("FAIL ack_pulse got %b exp 0000", ack); end
        for (int p = 0; p < 4; p++) begin
            frame_end = 1'b1; tick();
            frame_end = 1'b0; tick(); tick();
            vecs++;
            assert (dac_data === (p < 3 ? 8'hA5 : 8'h00))
                else begin errs++; $error("FAIL hold_frame%0d got %h", p, dac_data); end
        end
        vecs++;
        assert (busy === 1'b0) else begin errs++; $error("FAIL hold_end got %b exp 0", busy); end

        // round robin from a fresh pointer
        rst = 1'b0; tick(); rst = 1'b1; tick();
        data = 32'h40302010; req = 4'hF;
        for (int p = 0; p < 20; p++) begin
            frame_end = 1'b1; tick();
            if (ack !== 4'b0) seen.push_back(int'(grant_id));
            frame_end = 1'b0; tick(); tick();
        end
        vecs++;
        assert (seen.size() == 5) else begin errs++; $error("FAIL rr_grants got %0d exp 5", seen.size()); end
        foreach (seen[i]) begin
            vecs++;
            assert (seen[i] == i % 4) else begin errs++; $error("FAIL rr_order%0d got %0d exp %0d", i, seen[i], i % 4); end
        end
        req = '0; frame_end = 1'b1; tick(); frame_end = 1'b0; tick();

        // request that lives only between two frame pulses is never seen
        data = 32'h0000_7700;
        frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
        req = 4'b0010;
        for (int i = 0; i < 5; i++) tick();
        req = '0; tick();
        frame_end = 1'b1; tick(); frame_end = 1'b0; tick();
        vecs++;
        assert (dac_data === 8'h00 && busy === 1'b0)
            else begin errs++; $error("FAIL gated_req got %h/%b exp 00/0", dac_data, busy); end

        // sample captured at the grant edge only
        req = 4'b0010; frame_end = 1'b1; tick();
        frame_end = 1'b0; req = '0; data = 32'h0000_9900; tick(); tick();
        vecs++;
        assert (dac_data === 8'h77) else begin errs++; $error("FAIL capture got %h exp 77", dac_data); end
        for (int p = 0; p < 4; p++) begin frame_end = 1'b1; tick(); frame_end = 1'b0; tick(); end

        // reset in the middle of a hold
        data = 32'hC300_0000; req = 4'b1000; frame_end = 1'b1; tick();
        frame_end = 1'b0; req = '0; tick();
        for (int p = 0; p < 2; p++) begin frame_end = 1'b1; tick(); frame_end = 1'b0; tick(); end
        rst = 1'b0; tick(); rst = 1'b1;
        vecs++;
        assert (busy === 1'b0 && ack === 4'b0 && dac_data === 8'h00 && grant_id === 2'd0)
            else begin errs++; $error("FAIL midhold_reset got %b/%h/%0d/%b exp 0", ack, dac_data, grant_id, busy); end
        data = 32'h00005500; req = 4'b1010; frame_end = 1'b1; tick();
        frame_end = 1'b0; req = '0;
        vecs++;
        assert (grant_id === 2'd1 && ack === 4'b0010)
            else begin errs++; $error("FAIL post_reset_grant got %0d/%b exp 1/0010", grant_id, ack); end
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            frame_end = ($urandom_range(0, 2) == 0);
            req = 4'($urandom) & 4'($urandom);
            data = $urandom;
            tick();
        end
        rst = 1'b1; frame_end = 1'b0; req = '0;
        tick();

        // two requesters, one-frame holds, back-to-back frame pulses
        req2 = 2'b11; fe2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++;
            assert (gid2 === 1'(i % 2) && ack2 === (i % 2 == 1 ? 2'b10 : 2'b01) && dac2 === (i % 2 == 1 ? 8'hBB : 8'hAA) && busy2 === 1'b1)
                else begin errs++; $error("FAIL fast_rr%0d got %0d/%b/%h exp %0d", i, gid2, ack2, dac2, i % 2); end
        end
        fe2 = 1'b0; req2 = '0;
        tick();
        vecs++;
        assert (ack2 === 2'b00 && dac2 === 8'hBB) else begin errs++; $error("FAIL fast_rr_end got %b/%h exp 00/bb", ack2, dac2); end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
